// File: rtl/saed32_16x32_port_arbiter.sv
// saed32_16x32_port_arbiter
// Round-robin front end for one dual-port 16x32 SRAM wrapper. Up to two requesters
// are issued per cycle (first winner on port 0, second on port 1). Read data from the
// macro is steered back to the owning requester one cycle later with an rvalid strobe.
module saed32_16x32_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*DW-1:0]   req_wem,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW*NREQ-1:0]   rdata,
  output logic [AW-1:0]        A0,
  output logic [AW-1:0]        A1,
  output logic [DW-1:0]        D0,
  output logic [DW-1:0]        D1,
  output logic [DW-1:0]        WEM0,
  output logic [DW-1:0]        WEM1,
  output logic                 WE0,
  output logic                 WE1,
  output logic                 CE0,
  output logic                 CE1,
  input  logic [DW-1:0]        Q0,
  input  logic [DW-1:0]        Q1
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Round-robin pointer: the requester with the highest priority this cycle
  logic [PW-1:0] rr_ptr;

  // Per-requester views of the flattened request buses
  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];
  logic [DW-1:0] wem_a   [NREQ];

  // Scan results: first and second asserted request in round-robin order
  logic          found0, found1;
  logic [PW-1:0] w0, w1;
  logic          conflict;
  logic          issue0, issue1;
  logic [PW-1:0] next_after0, next_after1;

  // Read-return tags, one per port: {valid, owner}
  logic          tag0_v, tag1_v;
  logic [PW-1:0] tag0_o, tag1_o;

  // Unpack the flattened per-requester buses into arrays
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
      wem_a[i]   = req_wem[i*DW +: DW];
    end
  end

  // Walk the requesters starting at rr_ptr (wrapping) and pick the first two that ask
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    found0 = 1'b0;
    found1 = 1'b0;
    w0     = '0;
    w1     = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        if (!found0) begin
          found0 = 1'b1;
          w0     = idx;
        end else if (!found1) begin
          found1 = 1'b1;
          w1     = idx;
        end
      end
    end
  end

  // Hold back the second winner when it touches the same word as the first and either
  // side writes; it stays pending and becomes the first winner next cycle
  always_comb begin
    conflict    = found1 && (addr_a[w1] == addr_a[w0]) && (req_we[w0] || req_we[w1]);
    issue0      = RSTN && found0;
    issue1      = RSTN && found1 && !conflict;
    next_after0 = (w0 == PW'(NREQ-1)) ? '0 : w0 + 1'b1;
    next_after1 = (w1 == PW'(NREQ-1)) ? '0 : w1 + 1'b1;
  end

  // Drive grants and the SRAM pins; an idle port is fully zeroed
  always_comb begin
    gnt  = '0;
    CE0  = issue0;
    WE0  = issue0 && req_we[w0];
    A0   = issue0 ? addr_a[w0]  : '0;
    D0   = issue0 ? wdata_a[w0] : '0;
    WEM0 = issue0 ? wem_a[w0]   : '0;
    CE1  = issue1;
    WE1  = issue1 && req_we[w1];
    A1   = issue1 ? addr_a[w1]  : '0;
    D1   = issue1 ? wdata_a[w1] : '0;
    WEM1 = issue1 ? wem_a[w1]   : '0;
    if (issue0)
      gnt[w0] = 1'b1;
    if (issue1)
      gnt[w1] = 1'b1;
  end

  // Move priority to just past the last requester actually granted
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      rr_ptr <= '0;
    else if (issue1)
      rr_ptr <= next_after1;
    else if (issue0)
      rr_ptr <= next_after0;
  end

  // Remember which requester owns each port's read so Q can be routed next cycle
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tag0_v <= 1'b0;
      tag0_o <= '0;
      tag1_v <= 1'b0;
      tag1_o <= '0;
    end else begin
      tag0_v <= issue0 && !req_we[w0];
      tag0_o <= w0;
      tag1_v <= issue1 && !req_we[w1];
      tag1_o <= w1;
    end
  end

  // Steer each port's Q to its owner; the two owners are always distinct
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tag0_v && (tag0_o == PW'(i))) begin
        rvalid[i]          = 1'b1;
        rdata[i*DW +: DW]  = Q0;
      end else if (tag1_v && (tag1_o == PW'(i))) begin
        rvalid[i]          = 1'b1;
        rdata[i*DW +: DW]  = Q1;
      end
    end
  end

endmodule

// File: tb/tb_saed32_16x32_port_arbiter.sv
// tb_saed32_16x32_port_arbiter
// Drives the arbiter with directed scenarios and random traffic. A behavioural dual-port
// SRAM hangs off the macro pins; a queue-based reference model predicts grants, pin
// values and read returns from a shadow copy of memory.
module tb_saed32_16x32_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic                 CLK = 1'b0;
  logic                 RSTN;
  logic [NREQ-1:0]      req, req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata, req_wem;
  logic [NREQ-1:0]      gnt, rvalid;
  logic [DW*NREQ-1:0]   rdata;
  logic [AW-1:0]        A0, A1;
  logic [DW-1:0]        D0, D1, WEM0, WEM1;
  logic                 WE0, WE1, CE0, CE1;
  logic [DW-1:0]        Q0, Q1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_ptr;
  int            m_w0, m_w1;
  logic [3:0]    m_gnt;
  logic [31:0]   ref_mem [16];
  logic [3:0]    exp_rv;
  logic [31:0]   exp_rd [4];

  // Behavioural SRAM state
  logic          sram_init;
  logic [31:0]   mem [16];

  saed32_16x32_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wem(req_wem),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WEM0(WEM0), .WEM1(WEM1),
    .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1),
    .Q0(Q0), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  // Dual-port SRAM: masked writes, registered read data one cycle after CE
  always @(posedge CLK) begin
    if (sram_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      Q0 <= '0;
      Q1 <= '0;
    end else begin
      if (CE0) begin
        if (WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
        else     Q0 <= mem[A0];
      end
      if (CE1) begin
        if (WE1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
        else     Q1 <= mem[A1];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input bit we, input int addr,
                               input logic [31:0] wd, input logic [31:0] wem);
    req[i]               = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = 4'(addr);
    req_wdata[i*DW +: DW] = wd;
    req_wem[i*DW +: DW]   = wem;
  endtask

  task automatic clear_all();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wem = '0;
  endtask

  function automatic logic [3:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  // Reference arbitration: list requesters in priority order, take the first two
  task automatic model_comb();
    int cand[$];
    int c;
    m_w0 = -1;
    m_w1 = -1;
    m_gnt = '0;
    if (RSTN) begin
      for (int k = 0; k < NREQ; k++)
        if (req[(m_ptr + k) % NREQ]) cand.push_back((m_ptr + k) % NREQ);
      if (cand.size() >= 1) m_w0 = cand[0];
      if (cand.size() >= 2) begin
        c = cand[1];
        if (!(addr_of(c) == addr_of(m_w0) && (req_we[c] || req_we[m_w0]))) m_w1 = c;
      end
    end
    if (m_w0 >= 0) m_gnt[m_w0] = 1'b1;
    if (m_w1 >= 0) m_gnt[m_w1] = 1'b1;
  endtask

  // Reference state update at the clock edge
  task automatic model_seq();
    logic [3:0]  nrv;
    logic [31:0] nrd [4];
    int          ws[2];
    nrv = '0;
    for (int i = 0; i < 4; i++) nrd[i] = '0;
    ws[0] = m_w0;
    ws[1] = m_w1;
    for (int p = 0; p < 2; p++)
      if (ws[p] >= 0 && !req_we[ws[p]]) begin
        nrv[ws[p]] = 1'b1;
        nrd[ws[p]] = ref_mem[addr_of(ws[p])];
      end
    for (int p = 0; p < 2; p++)
      if (ws[p] >= 0 && req_we[ws[p]])
        ref_mem[addr_of(ws[p])] = (ref_mem[addr_of(ws[p])] & ~req_wem[ws[p]*DW +: DW])
                                | (req_wdata[ws[p]*DW +: DW] & req_wem[ws[p]*DW +: DW]);
    if (m_w1 >= 0)      m_ptr = (m_w1 + 1) % NREQ;
    else if (m_w0 >= 0) m_ptr = (m_w0 + 1) % NREQ;
    exp_rv = nrv;
    for (int i = 0; i < 4; i++) exp_rd[i] = nrd[i];
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance
  task automatic step_cycle();
    int a0, a1;
    #3;
    model_comb();
    a0 = m_w0;
    a1 = m_w1;
    checkOutput("gnt", gnt, m_gnt);
    checkOutput("ce0", CE0, a0 >= 0);
    checkOutput("ce1", CE1, a1 >= 0);
    checkOutput("we0", WE0, (a0 >= 0) ? req_we[a0] : 1'b0);
    checkOutput("we1", WE1, (a1 >= 0) ? req_we[a1] : 1'b0);
    checkOutput("a0", A0, (a0 >= 0) ? addr_of(a0) : 4'd0);
    checkOutput("a1", A1, (a1 >= 0) ? addr_of(a1) : 4'd0);
    checkOutput("d0", D0, (a0 >= 0) ? req_wdata[a0*DW +: DW] : 32'd0);
    checkOutput("d1", D1, (a1 >= 0) ? req_wdata[a1*DW +: DW] : 32'd0);
    checkOutput("wem0", WEM0, (a0 >= 0) ? req_wem[a0*DW +: DW] : 32'd0);
    checkOutput("wem1", WEM1, (a1 >= 0) ? req_wem[a1*DW +: DW] : 32'd0);
    checkOutput("rvalid", rvalid, exp_rv);
    for (int i = 0; i < NREQ; i++)
      if (exp_rv[i]) checkOutput($sformatf("rdata%0d", i), rdata[i*DW +: DW], exp_rd[i]);
    @(posedge CLK);
    model_seq();
    #1;
  endtask

  // Assert reset for one edge and check the forced-idle outputs while it is low
  task automatic do_reset();
    RSTN = 1'b0;
    #2;
    checkOutput("rst_gnt", gnt, 4'h0);
    checkOutput("rst_ce", {CE1, CE0}, 2'b00);
    checkOutput("rst_we", {WE1, WE0}, 2'b00);
    checkOutput("rst_rvalid", rvalid, 4'h0);
    @(posedge CLK);
    #1;
    clear_all();
    RSTN   = 1'b1;
    m_ptr  = 0;
    exp_rv = '0;
  endtask

  initial begin
    logic [31:0] ones;
    int r;
    ones = 32'hFFFF_FFFF;
    RSTN = 1'b0;
    sram_init = 1'b1;
    clear_all();
    req = 4'hF;
    req_we = 4'hF;
    m_ptr = 0;
    exp_rv = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 4; i++) exp_rd[i] = '0;
    @(posedge CLK);
    #1;
    sram_init = 1'b0;

    // Reset with every requester asking
    do_reset();

    // Write then read back one word
    do_reset();
    applyStimulus(0, 1, 3, 32'hDEAD_BEEF, ones);
    #1 checkOutput("t2_gnt_wr", gnt, 4'b0001);
    step_cycle();
    applyStimulus(0, 0, 3, 32'h0, 32'h0);
    #1 checkOutput("t2_gnt_rd", gnt, 4'b0001);
    step_cycle();
    clear_all();
    checkOutput("t2_rvalid", rvalid, 4'b0001);
    checkOutput("t2_rdata", rdata[31:0], 32'hDEAD_BEEF);
    step_cycle();

    // Dual issue from rr_ptr 0, then pointer lands on 3
    do_reset();
    applyStimulus(1, 0, 5, 32'h0, 32'h0);
    applyStimulus(2, 0, 6, 32'h0, 32'h0);
    #1 checkOutput("t3_gnt", gnt, 4'b0110);
    checkOutput("t3_a0", A0, 4'd5);
    checkOutput("t3_a1", A1, 4'd6);
    step_cycle();
    clear_all();
    checkOutput("t3_rvalid", rvalid, 4'b0110);
    applyStimulus(0, 0, 8, 32'h0, 32'h0);
    applyStimulus(3, 0, 9, 32'h0, 32'h0);
    #1 checkOutput("t3_ptr_a0", A0, 4'd9);
    checkOutput("t3_ptr_a1", A1, 4'd8);
    step_cycle();
    clear_all();
    step_cycle();

    // Same-address conflict: write wins, read follows next cycle with the new data
    do_reset();
    applyStimulus(0, 1, 7, 32'hA5A5_1234, ones);
    applyStimulus(1, 0, 7, 32'h0, 32'h0);
    #1 checkOutput("t4_gnt_n", gnt, 4'b0001);
    checkOutput("t4_ce1_n", CE1, 1'b0);
    step_cycle();
    req[0] = 1'b0;
    #1 checkOutput("t4_gnt_n1", gnt, 4'b0010);
    step_cycle();
    clear_all();
    checkOutput("t4_rvalid", rvalid, 4'b0010);
    checkOutput("t4_rdata", rdata[63:32], 32'hA5A5_1234);
    step_cycle();

    // Fairness: all four reading distinct words alternate in pairs
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(i, 0, 10 + i, 32'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      #1 checkOutput($sformatf("t5_gnt_c%0d", c), gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      step_cycle();
    end
    clear_all();
    step_cycle();

    // Masked write keeps the upper half
    do_reset();
    applyStimulus(0, 1, 2, ones, ones);
    step_cycle();
    applyStimulus(0, 1, 2, 32'h0, 32'h0000_FFFF);
    step_cycle();
    applyStimulus(0, 0, 2, 32'h0, 32'h0);
    step_cycle();
    clear_all();
    checkOutput("t6_rdata", rdata[31:0], 32'hFFFF_0000);
    step_cycle();

    // Reset while a read return is pending drops it
    do_reset();
    applyStimulus(2, 0, 2, 32'h0, 32'h0);
    step_cycle();
    clear_all();
    checkOutput("mid_rst_pre", rvalid, 4'b0100);
    RSTN = 1'b0;
    #1 checkOutput("mid_rst_drop", rvalid, 4'b0000);
    @(posedge CLK);
    #1;
    RSTN   = 1'b1;
    m_ptr  = 0;
    exp_rv = '0;
    step_cycle();

    // Random traffic: held requests may change address/data while waiting
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 99);
        if (!req[i] || m_gnt[i]) begin
          if (r < 60)
            applyStimulus(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom,
                          (r < 30) ? ones : $urandom);
          else
            req[i] = 1'b0;
        end else if (r < 20) begin
          applyStimulus(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, ones);
        end
      end
      step_cycle();
    end
    clear_all();
    step_cycle();
    step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
